// File: rtl/cu_state_sequencer.sv
// Control-unit state sequencer: fetch / decode / execute stepping with a
// memory-operation-complete watchdog that traps into a terminal bus-error state.
module cu_state_sequencer #(
  parameter int unsigned MOC_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  input  logic        cond_true,
  input  logic        moc,
  output logic [6:0]  state,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (MOC_TIMEOUT < 2) ? 1 : $clog2(MOC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

  typedef enum logic [6:0] {
    ST_RESET      = 7'd0,
    ST_FETCH0     = 7'd1,
    ST_FETCH1     = 7'd2,
    ST_FETCH_WAIT = 7'd3,
    ST_DECODE     = 7'd4,
    ST_DP_IMM     = 7'd10,
    ST_DP_REG     = 7'd11,
    ST_LD_ADDR    = 7'd20,
    ST_LD_MAR     = 7'd21,
    ST_LD_WAIT    = 7'd22,
    ST_LD_WB      = 7'd23,
    ST_ST_ADDR    = 7'd30,
    ST_ST_MAR     = 7'd31,
    ST_ST_WAIT    = 7'd32,
    ST_BR_LINK    = 7'd41,
    ST_BR_PC      = 7'd42,
    ST_BUSERR     = 7'd126,
    ST_UNDEF      = 7'd127
  } state_t;

  state_t           cur;
  logic [CNT_W-1:0] wait_cnt;

  // Condition field and operand bits are resolved elsewhere; only class/selector bits steer us.
  logic unused_ir;
  assign unused_ir = ^{ir[31:28], ir[23:21], ir[19:5], ir[3:0]};

  // Instruction class dispatch for a condition-passed instruction.
  function automatic state_t dispatch(input logic [31:0] i);
    state_t d;
    d = ST_UNDEF;
    case (i[27:25])
      3'b001: d = ST_DP_IMM;
      3'b000: d = i[4]  ? ST_UNDEF   : ST_DP_REG;
      3'b010: d = i[20] ? ST_LD_ADDR : ST_ST_ADDR;
      3'b101: d = i[24] ? ST_BR_LINK : ST_BR_PC;
      default: d = ST_UNDEF;
    endcase
    return d;
  endfunction

  // Successor of each wait state once memory reports completion.
  function automatic state_t wait_exit(input state_t s);
    state_t d;
    d = ST_FETCH0;
    case (s)
      ST_FETCH_WAIT: d = ST_DECODE;
      ST_LD_WAIT:    d = ST_LD_WB;
      default:       d = ST_FETCH0;
    endcase
    return d;
  endfunction

  assign state = cur;

  // State register, wait watchdog and bus-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur      <= ST_RESET;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
      case (cur)
        ST_RESET:   cur <= ST_FETCH0;
        ST_FETCH0:  cur <= ST_FETCH1;
        ST_FETCH1:  cur <= ST_FETCH_WAIT;
        ST_DECODE:  cur <= cond_true ? dispatch(ir) : ST_FETCH0;
        ST_DP_IMM, ST_DP_REG, ST_LD_WB, ST_BR_PC, ST_UNDEF:
                    cur <= ST_FETCH0;
        ST_LD_ADDR: cur <= ST_LD_MAR;
        ST_LD_MAR:  cur <= ST_LD_WAIT;
        ST_ST_ADDR: cur <= ST_ST_MAR;
        ST_ST_MAR:  cur <= ST_ST_WAIT;
        ST_BR_LINK: cur <= ST_BR_PC;
        ST_FETCH_WAIT, ST_LD_WAIT, ST_ST_WAIT: begin
          // Completion wins over a timeout landing on the same cycle.
          if (moc) begin
            cur <= wait_exit(cur);
          end else if (wait_cnt == CNT_LAST) begin
            cur     <= ST_BUSERR;
            bus_err <= 1'b1;
          end else begin
            cur      <= cur;
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_BUSERR: begin
          cur     <= ST_BUSERR;
          bus_err <= 1'b1;
        end
        default:    cur <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_state_sequencer.sv
// Scoreboard bench for cu_state_sequencer: expected state pushed per driven cycle,
// popped and compared one cycle later.
module tb_cu_state_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic        cond_true;
  logic        moc;
  logic [6:0]  state;
  logic        bus_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [7:0] exp_q[$];

  cu_state_sequencer #(.MOC_TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir        (ir),
    .cond_true (cond_true),
    .moc       (moc),
    .state     (state),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, record the expected post-edge state, then compare it.
  task automatic tick(input string tag, input logic r, input logic m, input logic [6:0] es);
    logic [7:0] e;
    rst_n = r;
    moc   = m;
    exp_q.push_back({(es == 7'd126), es});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".state"}, int'(state), int'(e[6:0]));
    chk({tag, ".bus_err"}, int'(bus_err), int'(e[7]));
  endtask

  // From FETCH0: FETCH1, enter FETCH_WAIT, n idle wait cycles, then complete into DECODE.
  task automatic fetch(input string tag, input int n);
    tick(tag, 1'b1, 1'b0, 7'd2);
    tick(tag, 1'b1, 1'b0, 7'd3);
    for (int i = 0; i < n; i++) tick(tag, 1'b1, 1'b0, 7'd3);
    tick(tag, 1'b1, 1'b1, 7'd4);
  endtask

  initial begin
    rst_n = 1'b0; moc = 1'b0; cond_true = 1'b1; ir = 32'hFFFF_FFFF;

    // Reset release and MOV immediate
    tick("rst", 1'b0, 1'b0, 7'd0);
    tick("rst_rel", 1'b1, 1'b0, 7'd1);
    fetch("mov", 1);
    ir = 32'hE3A01005;
    tick("mov", 1'b1, 1'b0, 7'd10);
    ir = 32'h0000_0000;
    tick("mov", 1'b1, 1'b0, 7'd1);

    // Load path with one-cycle completion
    fetch("ldr", 0);
    ir = 32'hE5912000;
    tick("ldr", 1'b1, 1'b0, 7'd20);
    ir = 32'hE0810012;
    tick("ldr", 1'b1, 1'b0, 7'd21);
    tick("ldr", 1'b1, 1'b0, 7'd22);
    tick("ldr", 1'b1, 1'b1, 7'd23);
    tick("ldr", 1'b1, 1'b0, 7'd1);

    // Branch-and-link, then same instruction with condition failed
    fetch("bl", 0);
    ir = 32'hEB000010;
    tick("bl", 1'b1, 1'b0, 7'd41);
    tick("bl", 1'b1, 1'b0, 7'd42);
    tick("bl", 1'b1, 1'b0, 7'd1);
    fetch("bl_nc", 0);
    cond_true = 1'b0;
    tick("bl_nc", 1'b1, 1'b0, 7'd1);
    cond_true = 1'b1;

    // Plain branch, store, register DP, and both undefined forms
    fetch("b", 0);
    ir = 32'hEA000010;
    tick("b", 1'b1, 1'b0, 7'd42);
    tick("b", 1'b1, 1'b0, 7'd1);
    fetch("str", 0);
    ir = 32'hE5812000;
    tick("str", 1'b1, 1'b0, 7'd30);
    tick("str", 1'b1, 1'b0, 7'd31);
    tick("str", 1'b1, 1'b0, 7'd32);
    tick("str", 1'b1, 1'b0, 7'd32);
    tick("str", 1'b1, 1'b1, 7'd1);
    fetch("dpr", 0);
    ir = 32'hE0810002;
    tick("dpr", 1'b1, 1'b0, 7'd11);
    tick("dpr", 1'b1, 1'b0, 7'd1);
    fetch("und0", 0);
    ir = 32'hE0810012;
    tick("und0", 1'b1, 1'b0, 7'd127);
    tick("und0", 1'b1, 1'b0, 7'd1);
    fetch("und3", 0);
    ir = 32'hE7000010;
    tick("und3", 1'b1, 1'b0, 7'd127);
    tick("und3", 1'b1, 1'b0, 7'd1);

    // Completion on the timeout cycle wins; counter restarts on each wait entry
    fetch("tmo_edge", 14);
    cond_true = 1'b0;
    tick("tmo_edge", 1'b1, 1'b0, 7'd1);
    cond_true = 1'b1;
    fetch("cnt_clr", 10);
    ir = 32'hE5912000;
    tick("cnt_clr", 1'b1, 1'b0, 7'd20);
    tick("cnt_clr", 1'b1, 1'b0, 7'd21);
    tick("cnt_clr", 1'b1, 1'b0, 7'd22);
    for (int i = 0; i < 14; i++) tick("cnt_clr", 1'b1, 1'b0, 7'd22);
    tick("cnt_clr", 1'b1, 1'b1, 7'd23);
    tick("cnt_clr", 1'b1, 1'b0, 7'd1);

    // Reset in the middle of a load wait
    fetch("ldrst", 0);
    tick("ldrst", 1'b1, 1'b0, 7'd20);
    tick("ldrst", 1'b1, 1'b0, 7'd21);
    tick("ldrst", 1'b1, 1'b0, 7'd22);
    tick("ldrst", 1'b1, 1'b0, 7'd22);
    tick("ldrst", 1'b0, 1'b1, 7'd0);
    tick("ldrst", 1'b1, 1'b0, 7'd1);

    // Fetch timeout into terminal bus error, then reset out of it
    tick("tmo", 1'b1, 1'b0, 7'd2);
    tick("tmo", 1'b1, 1'b0, 7'd3);
    for (int i = 0; i < 14; i++) tick("tmo", 1'b1, 1'b0, 7'd3);
    tick("tmo", 1'b1, 1'b0, 7'd126);
    tick("tmo_hold", 1'b1, 1'b1, 7'd126);
    tick("tmo_hold", 1'b1, 1'b0, 7'd126);
    tick("tmo_rst", 1'b0, 1'b0, 7'd0);
    tick("tmo_rst", 1'b0, 1'b0, 7'd0);
    tick("tmo_rel", 1'b1, 1'b0, 7'd1);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
